// File: rtl/instruction_fetch_ctrl.sv
`timescale 1ns/1ps
// Instruction fetch controller: PC sequencing, one in-flight fetch, one-entry skid buffer and output register.
// Optional misaligned-redirect fault detection is enabled by defining IFETCH_ALIGN_CHECK_EN.
module instruction_fetch_ctrl #(
    parameter int                   WORD_SIZE = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic [WORD_SIZE-1:0] imem_data,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic [WORD_SIZE-1:0] instr,
    output logic [WORD_SIZE-1:0] instr_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    output logic                 fetch_fault
`endif
);

    localparam logic [WORD_SIZE-1:0] PC_STEP = WORD_SIZE'(4);

`ifdef IFETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_FAULT} state_t;
`else
    typedef enum logic [1:0] {ST_RUN, ST_HOLD} state_t;
`endif

    state_t                 state_q, state_d;
    logic [WORD_SIZE-1:0]   pc_q, pc_d;
    logic                   inflight_valid_q, inflight_valid_d;
    logic [WORD_SIZE-1:0]   inflight_pc_q, inflight_pc_d;
    logic                   skid_valid_q, skid_valid_d;
    logic [WORD_SIZE-1:0]   skid_instr_q, skid_instr_d;
    logic [WORD_SIZE-1:0]   skid_pc_q, skid_pc_d;
    logic                   out_valid_q, out_valid_d;
    logic [WORD_SIZE-1:0]   out_instr_q, out_instr_d;
    logic [WORD_SIZE-1:0]   out_pc_q, out_pc_d;
    logic [WORD_SIZE-1:0]   redir_target;
    logic                   issue;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign redir_target = redirect_pc;
`else
    // Without the checker the low two bits are simply dropped.
    assign redir_target = redirect_pc & ~WORD_SIZE'(3);
`endif

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        inflight_valid_d = inflight_valid_q;
        inflight_pc_d    = inflight_pc_q;
        skid_valid_d     = skid_valid_q;
        skid_instr_d     = skid_instr_q;
        skid_pc_d        = skid_pc_q;
        out_valid_d      = out_valid_q;
        out_instr_d      = out_instr_q;
        out_pc_d         = out_pc_q;
        issue            = 1'b0;

`ifdef IFETCH_ALIGN_CHECK_EN
        if (state_q == ST_FAULT) begin
            inflight_valid_d = 1'b0;
            skid_valid_d     = 1'b0;
            out_valid_d      = 1'b0;
        end else
`endif
        if (redirect_valid) begin
            pc_d             = redir_target;
            inflight_valid_d = 1'b0;
            skid_valid_d     = 1'b0;
            out_valid_d      = 1'b0;
            state_d          = ST_RUN;
`ifdef IFETCH_ALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                state_d = ST_FAULT;
            end
`endif
        end else begin
            issue            = (state_q == ST_RUN) && (!out_valid_q || instr_ready);
            inflight_valid_d = issue;
            if (issue) begin
                inflight_pc_d = pc_q;
                pc_d          = pc_q + PC_STEP;
            end

            if (out_valid_q && !instr_ready) begin
                // Output stalled: a returning response parks in the skid and fetch stops.
                if (inflight_valid_q) begin
                    skid_valid_d = 1'b1;
                    skid_instr_d = imem_data;
                    skid_pc_d    = inflight_pc_q;
                    state_d      = ST_HOLD;
                end
            end else if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_instr_d  = skid_instr_q;
                out_pc_d     = skid_pc_q;
                skid_valid_d = 1'b0;
                state_d      = ST_RUN;
            end else if (inflight_valid_q) begin
                out_valid_d = 1'b1;
                out_instr_d = imem_data;
                out_pc_d    = inflight_pc_q;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_RUN;
            pc_q             <= RESET_PC;
            inflight_valid_q <= 1'b0;
            inflight_pc_q    <= '0;
            skid_valid_q     <= 1'b0;
            skid_instr_q     <= '0;
            skid_pc_q        <= '0;
            out_valid_q      <= 1'b0;
            out_instr_q      <= '0;
            out_pc_q         <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            inflight_valid_q <= inflight_valid_d;
            inflight_pc_q    <= inflight_pc_d;
            skid_valid_q     <= skid_valid_d;
            skid_instr_q     <= skid_instr_d;
            skid_pc_q        <= skid_pc_d;
            out_valid_q      <= out_valid_d;
            out_instr_q      <= out_instr_d;
            out_pc_q         <= out_pc_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr       = out_instr_q;
    assign instr_pc    = out_pc_q;
    assign instr_valid = out_valid_q;
`ifdef IFETCH_ALIGN_CHECK_EN
    assign fetch_fault = (state_q == ST_FAULT);
`endif

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
`timescale 1ns/1ps
// Testbench for instruction_fetch_ctrl: directed vector tables, hand-written corner sequences
// and a randomized run checked against an address-stream reference model.
module tb_instruction_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    instruction_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready)
`ifdef IFETCH_ALIGN_CHECK_EN
        ,
        .fetch_fault    (fetch_fault)
`endif
    );

    always #5 clk = ~clk;

    // Memory content is a fixed function of the address, so any word can be predicted.
    function automatic logic [31:0] fmem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
    endfunction

    always @(posedge clk) imem_data <= fmem(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic redir_cycle(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        cyc();
        redirect_valid = 1'b0;
    endtask

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          rdr;
        logic [31:0] rpc;
        bit          ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input bit rst, input bit rdy, input bit rdr, input logic [31:0] rpc,
                        input bit ev, input logic [31:0] epc, input logic [31:0] ea);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rdr = rdr; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.eaddr = ea;
        tbl.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_next, prev_instr, prev_pc, prev_addr, rpc;
        bit          prev_hold, rdy, rdr;
        int          since, transfers;

        // Streaming start, then a 3-cycle stall with skid fill and resume.
        addv(1, 1, 0, 0, 0, 32'h0,  32'h0);
        addv(0, 1, 0, 0, 0, 32'h0,  32'h4);
        addv(0, 1, 0, 0, 1, 32'h0,  32'h8);
        addv(0, 1, 0, 0, 1, 32'h4,  32'hC);
        addv(0, 1, 0, 0, 1, 32'h8,  32'h10);
        addv(0, 0, 0, 0, 1, 32'hC,  32'h14);
        addv(0, 0, 0, 0, 1, 32'hC,  32'h14);
        addv(0, 0, 0, 0, 1, 32'hC,  32'h14);
        addv(0, 1, 0, 0, 1, 32'hC,  32'h14);
        addv(0, 1, 0, 0, 1, 32'h10, 32'h14);
        addv(0, 1, 0, 0, 0, 32'h0,  32'h18);
        addv(0, 1, 0, 0, 1, 32'h14, 32'h1C);
        addv(0, 1, 0, 0, 1, 32'h18, 32'h20);
        // Redirect to 0 while 0xC is held and the skid is full.
        addv(1, 1, 0, 0, 0, 32'h0,  32'h0);
        addv(0, 1, 0, 0, 0, 32'h0,  32'h4);
        addv(0, 1, 0, 0, 1, 32'h0,  32'h8);
        addv(0, 1, 0, 0, 1, 32'h4,  32'hC);
        addv(0, 1, 0, 0, 1, 32'h8,  32'h10);
        addv(0, 0, 0, 0, 1, 32'hC,  32'h14);
        addv(0, 0, 0, 0, 1, 32'hC,  32'h14);
        addv(0, 0, 1, 0, 1, 32'hC,  32'h14);
        addv(0, 1, 0, 0, 0, 32'h0,  32'h0);
        addv(0, 1, 0, 0, 0, 32'h0,  32'h4);
        addv(0, 1, 0, 0, 1, 32'h0,  32'h8);
        addv(0, 1, 0, 0, 1, 32'h4,  32'hC);
        addv(0, 1, 0, 0, 1, 32'h8,  32'h10);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            else cyc();
            instr_ready    = tbl[i].rdy;
            redirect_valid = tbl[i].rdr;
            redirect_pc    = tbl[i].rpc;
            $display("vec %0d rdy=%0b redir=%0b valid=%0b instr_pc=%h addr=%h",
                     i, tbl[i].rdy, tbl[i].rdr, instr_valid, instr_pc, imem_addr);
            chk($sformatf("tbl%0d_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].ev});
            chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].eaddr);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].epc);
                chk($sformatf("tbl%0d_instr", i), instr, fmem(tbl[i].epc));
            end
        end
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;

        // Asynchronous reset between clock edges while in HOLD.
        do_reset();
        repeat (5) cyc();
        instr_ready = 1'b0;
        cyc();
        cyc();
        chk("hold_valid", {31'b0, instr_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("async_rst_instr", instr, 32'h0);
        chk("async_rst_pc", instr_pc, 32'h0);
        chk("async_rst_addr", imem_addr, 32'h0);
`ifdef IFETCH_ALIGN_CHECK_EN
        chk("async_rst_fault", {31'b0, fetch_fault}, 32'd0);
`endif
        @(negedge clk);
        instr_ready = 1'b1;
        rst_n       = 1'b1;
        cyc();
        chk("restart_e1_valid", {31'b0, instr_valid}, 32'd0);
        cyc();
        chk("restart_e2_valid", {31'b0, instr_valid}, 32'd1);
        chk("restart_e2_pc", instr_pc, 32'h0);
        $display("seq async_reset: restart instr_pc=%h", instr_pc);

        // PC wrap at the top of the address space.
        do_reset();
        repeat (3) cyc();
        redir_cycle(32'hFFFF_FFFC);
        chk("wrap_redir_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_redir_valid", {31'b0, instr_valid}, 32'd0);
        cyc();
        chk("wrap_next_addr", imem_addr, 32'h0);
        cyc();
        chk("wrap_first_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_first_instr", instr, fmem(32'hFFFF_FFFC));
        cyc();
        chk("wrap_second_pc", instr_pc, 32'h0);
        chk("wrap_second_instr", instr, fmem(32'h0));
        $display("seq wrap: instr_pc=%h", instr_pc);

        // Back-to-back redirects: only the last target is fetched.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cyc();
        redirect_pc = 32'h200;
        cyc();
        redirect_valid = 1'b0;
        chk("dbl_redir_addr", imem_addr, 32'h200);
        chk("dbl_redir_valid0", {31'b0, instr_valid}, 32'd0);
        cyc();
        chk("dbl_redir_valid1", {31'b0, instr_valid}, 32'd0);
        cyc();
        chk("dbl_redir_valid2", {31'b0, instr_valid}, 32'd1);
        chk("dbl_redir_pc", instr_pc, 32'h200);
        $display("seq double_redirect: instr_pc=%h", instr_pc);

        // Misaligned redirect.
        redir_cycle(32'h6);
`ifdef IFETCH_ALIGN_CHECK_EN
        chk("fault_set", {31'b0, fetch_fault}, 32'd1);
        chk("fault_valid", {31'b0, instr_valid}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("fault_stay%0d", k), {31'b0, fetch_fault}, 32'd1);
            chk($sformatf("fault_novalid%0d", k), {31'b0, instr_valid}, 32'd0);
        end
        redir_cycle(32'h40);
        chk("fault_ignores_redir", {31'b0, fetch_fault}, 32'd1);
        do_reset();
        chk("fault_cleared", {31'b0, fetch_fault}, 32'd0);
        $display("seq misaligned: fault raised and cleared by reset");
`else
        chk("misalign_addr", imem_addr, 32'h4);
        cyc();
        cyc();
        chk("misalign_valid", {31'b0, instr_valid}, 32'd1);
        chk("misalign_pc", instr_pc, 32'h4);
        $display("seq misaligned: instr_pc=%h", instr_pc);
`endif

        // Randomized run against the expected address stream.
        do_reset();
        since     = 1;
        exp_next  = 32'h0;
        prev_hold = 1'b0;
        transfers = 0;
        prev_instr = '0; prev_pc = '0; prev_addr = '0;
        for (int n = 0; n < 1200; n++) begin
            if (since == 1 || since == 2)
                chk("rnd_redir_bubble", {31'b0, instr_valid}, 32'd0);
            if (since == 3)
                chk("rnd_redir_latency", {31'b0, instr_valid}, 32'd1);
            if (prev_hold) begin
                chk("rnd_hold_instr", instr, prev_instr);
                chk("rnd_hold_pc", instr_pc, prev_pc);
                chk("rnd_hold_addr", imem_addr, prev_addr);
            end
            if (instr_valid) begin
                chk("rnd_pc", instr_pc, exp_next);
                chk("rnd_instr", instr, fmem(instr_pc));
            end
            rdy = ($urandom_range(0, 3) != 0);
            rdr = ($urandom_range(0, 23) == 0);
            rpc = $urandom;
`ifdef IFETCH_ALIGN_CHECK_EN
            rpc[1:0] = 2'b00;
`endif
            instr_ready    = rdy;
            redirect_valid = rdr;
            redirect_pc    = rpc;
            prev_hold  = instr_valid && !rdy && !rdr;
            prev_instr = instr;
            prev_pc    = instr_pc;
            prev_addr  = imem_addr;
            if (rdr) begin
                exp_next = {rpc[31:2], 2'b00};
                since    = 0;
            end else if (instr_valid && rdy) begin
                $display("rnd xfer %0d: instr_pc=%h instr=%h", transfers, instr_pc, instr);
                exp_next  = exp_next + 32'd4;
                transfers = transfers + 1;
            end
            cyc();
            if (since < 1000) since = since + 1;
        end
        redirect_valid = 1'b0;
        chk("rnd_liveness", {31'b0, transfers > 300}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
